// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory command/data channel between I$ refills and
// D$ refills/writebacks, with a registered, source-tagged read-return router.
module cache_mem_arbiter #(
  parameter int TIDW   = 6,
  parameter int LADDRW = 27,
  parameter int BEATW  = 128
) (
  input  logic              gclk,
  input  logic              rstn,
  input  logic              ic_req_valid,
  input  logic [TIDW-1:0]   ic_req_tid,
  input  logic [LADDRW-1:0] ic_req_addr,
  output logic              ic_req_ready,
  input  logic              dc_req_valid,
  input  logic              dc_req_op,
  input  logic [TIDW-1:0]   dc_req_tid,
  input  logic [LADDRW-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [BEATW-1:0]  dc_wdata,
  output logic              dc_wdata_ready,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_we,
  output logic              mem_cmd_src,
  output logic [TIDW-1:0]   mem_cmd_tid,
  output logic [LADDRW-1:0] mem_cmd_addr,
  input  logic              mem_cmd_ready,
  output logic              mem_wdata_valid,
  output logic [BEATW-1:0]  mem_wdata,
  input  logic              mem_wdata_ready,
  input  logic              mem_rdata_valid,
  input  logic              mem_rdata_src,
  input  logic [TIDW-1:0]   mem_rdata_tid,
  input  logic [BEATW-1:0]  mem_rdata,
  output logic              ic_rdata_valid,
  output logic              dc_rdata_valid,
  output logic [TIDW-1:0]   rdata_tid,
  output logic [BEATW-1:0]  rdata,
  output logic              rdata_beat
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WB0, ST_WB1} state_e;

  localparam logic SRC_IC = 1'b0;
  localparam logic SRC_DC = 1'b1;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_src_q, cmd_src_d;
  logic [TIDW-1:0]   cmd_tid_q, cmd_tid_d;
  logic [LADDRW-1:0] cmd_addr_q, cmd_addr_d;
  logic              grant_ic, grant_dc;

  logic              ic_rv_q, ic_rv_d;
  logic              dc_rv_q, dc_rv_d;
  logic [TIDW-1:0]   rdata_tid_q, rdata_tid_d;
  logic [BEATW-1:0]  rdata_q, rdata_d;
  logic              rdata_beat_q, rdata_beat_d;
  logic              tog_ic_q, tog_ic_d;
  logic              tog_dc_q, tog_dc_d;

  // Command-side FSM: grant, present the latched command, then stream writeback beats.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    cmd_we_d        = cmd_we_q;
    cmd_src_d       = cmd_src_q;
    cmd_tid_d       = cmd_tid_q;
    cmd_addr_d      = cmd_addr_q;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_cmd_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_wdata       = '0;
    dc_wdata_ready  = 1'b0;
    // On a tie the requester that did not win last time is served.
    grant_ic = ic_req_valid && (!dc_req_valid || rr_last_q == SRC_DC);
    grant_dc = dc_req_valid && (!ic_req_valid || rr_last_q == SRC_IC);

    unique case (state_q)
      ST_IDLE: begin
        // Grant is suppressed while rstn is low so ready stays 0 throughout reset.
        if (rstn && grant_ic) begin
          ic_req_ready = 1'b1;
          cmd_we_d     = 1'b0;
          cmd_src_d    = SRC_IC;
          cmd_tid_d    = ic_req_tid;
          cmd_addr_d   = ic_req_addr;
          rr_last_d    = SRC_IC;
          state_d      = ST_CMD;
        end else if (rstn && grant_dc) begin
          dc_req_ready = 1'b1;
          cmd_we_d     = dc_req_op;
          cmd_src_d    = SRC_DC;
          cmd_tid_d    = dc_req_tid;
          cmd_addr_d   = dc_req_addr;
          rr_last_d    = SRC_DC;
          state_d      = ST_CMD;
        end
      end
      ST_CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = cmd_we_q ? ST_WB0 : ST_IDLE;
      end
      ST_WB0, ST_WB1: begin
        mem_wdata_valid = 1'b1;
        mem_wdata       = dc_wdata;
        dc_wdata_ready  = mem_wdata_ready;
        if (mem_wdata_ready) state_d = (state_q == ST_WB0) ? ST_WB1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_cmd_we   = cmd_we_q;
  assign mem_cmd_src  = cmd_src_q;
  assign mem_cmd_tid  = cmd_tid_q;
  assign mem_cmd_addr = cmd_addr_q;

  // Read return router: one registered output beat per returning beat, per-source beat toggles.
  always_comb begin
    ic_rv_d      = mem_rdata_valid && (mem_rdata_src == SRC_IC);
    dc_rv_d      = mem_rdata_valid && (mem_rdata_src == SRC_DC);
    rdata_d      = rdata_q;
    rdata_tid_d  = rdata_tid_q;
    rdata_beat_d = rdata_beat_q;
    tog_ic_d     = tog_ic_q;
    tog_dc_d     = tog_dc_q;
    if (mem_rdata_valid) begin
      rdata_d     = mem_rdata;
      rdata_tid_d = mem_rdata_tid;
      if (mem_rdata_src == SRC_IC) begin
        rdata_beat_d = tog_ic_q;
        tog_ic_d     = !tog_ic_q;
      end else begin
        rdata_beat_d = tog_dc_q;
        tog_dc_d     = !tog_dc_q;
      end
    end
  end

  assign ic_rdata_valid = ic_rv_q;
  assign dc_rdata_valid = dc_rv_q;
  assign rdata_tid      = rdata_tid_q;
  assign rdata          = rdata_q;
  assign rdata_beat     = rdata_beat_q;

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= SRC_DC;
      cmd_we_q     <= 1'b0;
      cmd_src_q    <= 1'b0;
      cmd_tid_q    <= '0;
      cmd_addr_q   <= '0;
      ic_rv_q      <= 1'b0;
      dc_rv_q      <= 1'b0;
      rdata_tid_q  <= '0;
      rdata_q      <= '0;
      rdata_beat_q <= 1'b0;
      tog_ic_q     <= 1'b0;
      tog_dc_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      cmd_we_q     <= cmd_we_d;
      cmd_src_q    <= cmd_src_d;
      cmd_tid_q    <= cmd_tid_d;
      cmd_addr_q   <= cmd_addr_d;
      ic_rv_q      <= ic_rv_d;
      dc_rv_q      <= dc_rv_d;
      rdata_tid_q  <= rdata_tid_d;
      rdata_q      <= rdata_d;
      rdata_beat_q <= rdata_beat_d;
      tog_ic_q     <= tog_ic_d;
      tog_dc_q     <= tog_dc_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int TIDW   = 6;
  localparam int LADDRW = 27;
  localparam int BEATW  = 128;

  logic              gclk = 1'b0;
  logic              rstn = 1'b0;
  logic              ic_req_valid = 1'b0;
  logic [TIDW-1:0]   ic_req_tid = '0;
  logic [LADDRW-1:0] ic_req_addr = '0;
  logic              ic_req_ready;
  logic              dc_req_valid = 1'b0;
  logic              dc_req_op = 1'b0;
  logic [TIDW-1:0]   dc_req_tid = '0;
  logic [LADDRW-1:0] dc_req_addr = '0;
  logic              dc_req_ready;
  logic [BEATW-1:0]  dc_wdata = '0;
  logic              dc_wdata_ready;
  logic              mem_cmd_valid, mem_cmd_we, mem_cmd_src;
  logic [TIDW-1:0]   mem_cmd_tid;
  logic [LADDRW-1:0] mem_cmd_addr;
  logic              mem_cmd_ready = 1'b0;
  logic              mem_wdata_valid;
  logic [BEATW-1:0]  mem_wdata;
  logic              mem_wdata_ready = 1'b0;
  logic              mem_rdata_valid = 1'b0;
  logic              mem_rdata_src = 1'b0;
  logic [TIDW-1:0]   mem_rdata_tid = '0;
  logic [BEATW-1:0]  mem_rdata = '0;
  logic              ic_rdata_valid, dc_rdata_valid;
  logic [TIDW-1:0]   rdata_tid;
  logic [BEATW-1:0]  rdata;
  logic              rdata_beat;

  cache_mem_arbiter #(.TIDW(TIDW), .LADDRW(LADDRW), .BEATW(BEATW)) dut (
    .gclk(gclk), .rstn(rstn),
    .ic_req_valid(ic_req_valid), .ic_req_tid(ic_req_tid), .ic_req_addr(ic_req_addr),
    .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_op(dc_req_op), .dc_req_tid(dc_req_tid),
    .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
    .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we), .mem_cmd_src(mem_cmd_src),
    .mem_cmd_tid(mem_cmd_tid), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_ready(mem_cmd_ready),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata_src(mem_rdata_src),
    .mem_rdata_tid(mem_rdata_tid), .mem_rdata(mem_rdata),
    .ic_rdata_valid(ic_rdata_valid), .dc_rdata_valid(dc_rdata_valid),
    .rdata_tid(rdata_tid), .rdata(rdata), .rdata_beat(rdata_beat)
  );

  always #5 gclk = ~gclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding operation with a pending command and a
  // count of write beats still owed; returned beats counted per source.
  bit              m_busy = 0;
  bit              m_cmd_pend = 0;
  int              m_beats_left = 0;
  bit              m_last_src = 1;
  bit              m_we = 0, m_src = 0;
  logic [TIDW-1:0]   m_tid = '0;
  logic [LADDRW-1:0] m_addr = '0;
  int              m_seen[2] = '{0, 0};
  bit              m_rd_ic = 0, m_rd_dc = 0, m_rd_beat = 0;
  logic [TIDW-1:0]   m_rd_tid = '0;
  logic [BEATW-1:0]  m_rd_data = '0;

  always @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 0; m_cmd_pend <= 0; m_beats_left <= 0; m_last_src <= 1;
      m_we <= 0; m_src <= 0; m_tid <= '0; m_addr <= '0;
      m_seen[0] <= 0; m_seen[1] <= 0;
      m_rd_ic <= 0; m_rd_dc <= 0; m_rd_beat <= 0; m_rd_tid <= '0; m_rd_data <= '0;
    end else begin
      m_rd_ic <= mem_rdata_valid && !mem_rdata_src;
      m_rd_dc <= mem_rdata_valid && mem_rdata_src;
      if (mem_rdata_valid) begin
        m_rd_tid  <= mem_rdata_tid;
        m_rd_data <= mem_rdata;
        m_rd_beat <= (m_seen[int'(mem_rdata_src)] % 2) == 1;
        m_seen[int'(mem_rdata_src)] <= m_seen[int'(mem_rdata_src)] + 1;
      end
      if (!m_busy) begin
        if (ic_req_valid && (!dc_req_valid || m_last_src)) begin
          m_busy <= 1; m_cmd_pend <= 1; m_we <= 0; m_src <= 0;
          m_tid <= ic_req_tid; m_addr <= ic_req_addr; m_beats_left <= 0; m_last_src <= 0;
        end else if (dc_req_valid) begin
          m_busy <= 1; m_cmd_pend <= 1; m_we <= dc_req_op; m_src <= 1;
          m_tid <= dc_req_tid; m_addr <= dc_req_addr; m_beats_left <= dc_req_op ? 2 : 0;
          m_last_src <= 1;
        end
      end else if (m_cmd_pend) begin
        if (mem_cmd_ready) begin
          m_cmd_pend <= 0;
          if (m_beats_left == 0) m_busy <= 0;
        end
      end else if (mem_wdata_ready) begin
        m_beats_left <= m_beats_left - 1;
        if (m_beats_left == 1) m_busy <= 0;
      end
    end
  end

  // Compare process: outputs checked mid-cycle against the model, every cycle.
  always begin
    bit exp_ic_rdy, exp_dc_rdy, exp_cmd_v, exp_wv;
    @(negedge gclk);
    #2;
    exp_ic_rdy = rstn && !m_busy && ic_req_valid && (!dc_req_valid || m_last_src);
    exp_dc_rdy = rstn && !m_busy && dc_req_valid && (!ic_req_valid || !m_last_src);
    exp_cmd_v  = m_busy && m_cmd_pend;
    exp_wv     = m_busy && !m_cmd_pend;
    check("cmp_ic_req_ready", ic_req_ready, exp_ic_rdy);
    check("cmp_dc_req_ready", dc_req_ready, exp_dc_rdy);
    check("cmp_mem_cmd_valid", mem_cmd_valid, exp_cmd_v);
    if (exp_cmd_v)
      check("cmp_cmd_fields", {mem_cmd_we, mem_cmd_src, mem_cmd_tid, mem_cmd_addr},
            {m_we, m_src, m_tid, m_addr});
    check("cmp_mem_wdata_valid", mem_wdata_valid, exp_wv);
    check("cmp_mem_wdata", mem_wdata, exp_wv ? dc_wdata : '0);
    check("cmp_dc_wdata_ready", dc_wdata_ready, exp_wv && mem_wdata_ready);
    check("cmp_rd_strobes", {ic_rdata_valid, dc_rdata_valid}, {m_rd_ic, m_rd_dc});
    check("cmp_rd_tag", {rdata_tid, rdata_beat}, {m_rd_tid, m_rd_beat});
    check("cmp_rdata", rdata, m_rd_data);
  end

  task automatic idle_inputs();
    ic_req_valid = 0; dc_req_valid = 0; dc_req_op = 0;
    mem_cmd_ready = 0; mem_wdata_ready = 0; mem_rdata_valid = 0;
  endtask

  task automatic reset_pulse();
    @(negedge gclk);
    rstn = 0;
    idle_inputs();
    @(negedge gclk);
    rstn = 1;
  endtask

  localparam logic [BEATW-1:0] BEAT_A = {32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004};
  localparam logic [BEATW-1:0] BEAT_B = {32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 32'hBBBB0004};

  initial begin
    int grants[$];
    int grant_k[$];
    int cmd_cycles, pulses, nbeats, ic_grant_k;
    logic [BEATW-1:0] got_beat[2];
    bit ic_hs, dc_hs;
    logic [BEATW-1:0] rd_data[4];
    bit rd_src[4];
    logic [TIDW-1:0] rd_tid[4];
    bit exp_beat[4];

    // Reset state, with requests and a read return already presented.
    rstn = 0;
    ic_req_valid = 1; dc_req_valid = 1; mem_rdata_valid = 1;
    #7;
    check("rst_ic_req_ready", ic_req_ready, 0);
    check("rst_dc_req_ready", dc_req_ready, 0);
    check("rst_cmd", {mem_cmd_valid, mem_cmd_we, mem_cmd_src, mem_cmd_tid, mem_cmd_addr}, 0);
    check("rst_wdata", {mem_wdata_valid, dc_wdata_ready, mem_wdata}, 0);
    check("rst_rd", {ic_rdata_valid, dc_rdata_valid, rdata_beat, rdata_tid, rdata}, 0);
    idle_inputs();
    @(negedge gclk);
    rstn = 1;

    // Single I$ refill.
    @(negedge gclk);
    ic_req_valid = 1; ic_req_tid = 6'd5; ic_req_addr = 27'h0001234; mem_cmd_ready = 1;
    #3;
    check("t1_ic_ready", ic_req_ready, 1);
    check("t1_cmd_not_yet", mem_cmd_valid, 0);
    @(negedge gclk);
    ic_req_valid = 0;
    #3;
    check("t1_cmd_valid", mem_cmd_valid, 1);
    check("t1_cmd_fields", {mem_cmd_we, mem_cmd_src, mem_cmd_tid, mem_cmd_addr},
          {1'b0, 1'b0, 6'd5, 27'h0001234});
    @(negedge gclk);
    #3;
    check("t1_back_idle", mem_cmd_valid, 0);

    // Both valid continuously after reset: I$, D$, I$, D$ with one CMD cycle between grants.
    reset_pulse();
    for (int k = 0; k < 12 && grants.size() < 4; k++) begin
      @(negedge gclk);
      ic_req_valid = 1; ic_req_tid = 6'd1; ic_req_addr = 27'h0000100;
      dc_req_valid = 1; dc_req_op = 0; dc_req_tid = 6'd2; dc_req_addr = 27'h0000200;
      mem_cmd_ready = 1;
      #3;
      if (ic_req_ready) begin grants.push_back(0); grant_k.push_back(k); end
      if (dc_req_ready) begin grants.push_back(1); grant_k.push_back(k); end
    end
    @(negedge gclk);
    idle_inputs();
    check("t2_grant_count", grants.size(), 4);
    if (grants.size() == 4) begin
      check("t2_order", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 4'b0101);
      check("t2_spacing", grant_k[3] - grant_k[0], 6);
    end

    // D$ writeback with command and beat stalls, I$ request held throughout.
    @(negedge gclk);
    mem_cmd_ready = 1;
    @(negedge gclk);
    dc_req_valid = 1; dc_req_op = 1; dc_req_tid = 6'd3; dc_req_addr = 27'h0ABCDEF;
    mem_cmd_ready = 0; mem_wdata_ready = 0; dc_wdata = BEAT_A;
    #3;
    check("t3_wb_grant", dc_req_ready, 1);
    cmd_cycles = 0; pulses = 0; nbeats = 0; ic_grant_k = -1;
    got_beat[0] = '0; got_beat[1] = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge gclk);
      dc_req_valid = 0;
      ic_req_valid = 1; ic_req_tid = 6'd7; ic_req_addr = 27'h0000777;
      mem_cmd_ready = (k == 4);
      mem_wdata_ready = (k >= 7);
      dc_wdata = (nbeats == 0) ? BEAT_A : BEAT_B;
      #3;
      if (mem_cmd_valid) begin
        cmd_cycles++;
        check("t3_cmd_stable", {mem_cmd_we, mem_cmd_src, mem_cmd_tid, mem_cmd_addr},
              {1'b1, 1'b1, 6'd3, 27'h0ABCDEF});
      end
      if (dc_wdata_ready) begin
        pulses++;
        if (nbeats < 2) got_beat[nbeats] = mem_wdata;
        nbeats++;
      end
      if (ic_req_ready) begin
        ic_grant_k = k;
        break;
      end
    end
    check("t3_cmd_cycles", cmd_cycles, 4);
    check("t3_wready_pulses", pulses, 2);
    check("t3_beat_a", got_beat[0], BEAT_A);
    check("t3_beat_b", got_beat[1], BEAT_B);
    check("t3_ic_grant_after_wb", ic_grant_k, 9);
    @(negedge gclk);
    idle_inputs();
    mem_cmd_ready = 1;
    repeat (2) @(negedge gclk);

    // Interleaved read returns from both sources.
    reset_pulse();
    rd_src  = '{0, 1, 0, 1};
    rd_tid  = '{6'd1, 6'd2, 6'd1, 6'd2};
    rd_data = '{128'h1111, 128'h2222, 128'h3333, 128'h4444};
    exp_beat = '{0, 0, 1, 1};
    for (int k = 0; k <= 4; k++) begin
      @(negedge gclk);
      mem_rdata_valid = (k < 4);
      if (k < 4) begin
        mem_rdata_src = rd_src[k]; mem_rdata_tid = rd_tid[k]; mem_rdata = rd_data[k];
      end
      #3;
      if (k == 0) check("t4_no_early_out", {ic_rdata_valid, dc_rdata_valid}, 2'b00);
      else begin
        check("t4_strobes", {ic_rdata_valid, dc_rdata_valid}, {!rd_src[k-1], rd_src[k-1]});
        check("t4_tid_beat", {rdata_tid, rdata_beat}, {rd_tid[k-1], exp_beat[k-1]});
        check("t4_data", rdata, rd_data[k-1]);
      end
    end
    idle_inputs();

    // Reset asserted during the second writeback beat.
    @(negedge gclk);
    dc_req_valid = 1; dc_req_op = 1; dc_req_tid = 6'd9; dc_req_addr = 27'h0000999;
    mem_cmd_ready = 1; mem_wdata_ready = 1; dc_wdata = BEAT_A;
    @(negedge gclk);
    dc_req_valid = 0;
    @(negedge gclk);
    @(negedge gclk);
    mem_wdata_ready = 0; ic_req_valid = 1; dc_wdata = BEAT_B;
    #3;
    check("t5_in_wb1", mem_wdata_valid, 1);
    rstn = 0;
    #1;
    check("t5_rst_ready", {ic_req_ready, dc_req_ready, dc_wdata_ready}, 0);
    check("t5_rst_cmd", {mem_cmd_valid, mem_cmd_we, mem_cmd_src, mem_cmd_tid, mem_cmd_addr}, 0);
    check("t5_rst_wdata", {mem_wdata_valid, mem_wdata}, 0);
    check("t5_rst_rd", {ic_rdata_valid, dc_rdata_valid, rdata_beat, rdata_tid, rdata}, 0);
    @(negedge gclk);
    rstn = 1;
    ic_req_valid = 1; ic_req_tid = 6'd4; ic_req_addr = 27'h0000444;
    dc_req_valid = 1; dc_req_op = 0; dc_req_tid = 6'd8; dc_req_addr = 27'h0000888;
    mem_wdata_ready = 1;
    #3;
    check("t5_ic_first", {ic_req_ready, dc_req_ready}, 2'b10);
    @(negedge gclk);
    ic_req_valid = 0;

    // Randomized traffic, checked by the compare process against the model.
    ic_hs = 0; dc_hs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge gclk);
      rstn = !(c % 997 == 996);
      if (!ic_req_valid || ic_hs) begin
        ic_req_valid = ($urandom % 3) != 0;
        ic_req_tid = TIDW'($urandom); ic_req_addr = LADDRW'($urandom);
      end
      if (!dc_req_valid || dc_hs) begin
        dc_req_valid = ($urandom % 3) != 0;
        dc_req_op = 1'($urandom);
        dc_req_tid = TIDW'($urandom); dc_req_addr = LADDRW'($urandom);
      end
      mem_cmd_ready = ($urandom % 4) != 0;
      mem_wdata_ready = ($urandom % 3) != 0;
      dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      mem_rdata_valid = 1'($urandom);
      mem_rdata_src = 1'($urandom);
      mem_rdata_tid = TIDW'($urandom);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #3;
      ic_hs = ic_req_valid && ic_req_ready;
      dc_hs = dc_req_valid && dc_req_ready;
    end
    @(negedge gclk);
    rstn = 1;
    idle_inputs();
    repeat (3) @(negedge gclk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
